// File: rtl/if_stage_pkg.sv
// Shared defines for the instruction fetch stage: bus widths, reset level and
// direct-mapped instruction cache geometry.
package if_stage_pkg;

   localparam logic RstEnable   = 1'b1;
   localparam int   InstAddrBus = 32;
   localparam int   InstBus     = 32;

   localparam logic [InstBus-1:0] ZeroWord = '0;

   localparam int ICacheIndexBus = 5;
   localparam int ICacheTagBus   = 11;
   localparam int ICacheDepth    = 1 << ICacheIndexBus;
   localparam int ICacheIndexLsb = 2;
   localparam int ICacheTagLsb   = ICacheIndexLsb + ICacheIndexBus;

   // Byte counters run 0..4 per word, hence one bit wider than a byte index.
   typedef logic [2:0] byte_cnt_t;

   localparam byte_cnt_t WordBytes = 3'd4;
   localparam byte_cnt_t LastByte  = 3'd3;

endpackage

// File: rtl/if_stage_icache.sv
// Direct-mapped instruction cache for the fetch stage (built only with ICACHE_EN):
// asynchronous lookup, single-word fill, valid bits cleared by reset alone.
module icache
   import if_stage_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ICacheIndexBus-1:0] lookup_index,
   input  logic [ICacheTagBus-1:0]   lookup_tag,
   output logic                      hit,
   output logic [InstBus-1:0]        hit_data,
   input  logic                      fill_en,
   input  logic [ICacheIndexBus-1:0] fill_index,
   input  logic [ICacheTagBus-1:0]   fill_tag,
   input  logic [InstBus-1:0]        fill_data
);

   logic [ICacheDepth-1:0]  valid_q;
   logic [ICacheTagBus-1:0] tag_q  [ICacheDepth];
   logic [InstBus-1:0]      data_q [ICacheDepth];

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[fill_index] <= 1'b1;
      end
   end

   // NOTE: tag/data arrays carry no reset; the valid bits alone make stale contents harmless.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[fill_index]  <= fill_tag;
         data_q[fill_index] <= fill_data;
      end
   end

   assign hit      = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
   assign hit_data = data_q[lookup_index];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: assembles 32-bit little-endian words from a byte memory port.
// Define ICACHE_EN to add a 32-entry direct-mapped instruction cache in front of the port.
module if_stage
   import if_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   jump_i,
   input  logic [InstAddrBus-1:0] jump_addr_i,
   input  logic                   mem_grant_i,
   input  logic [7:0]             mem_data_i,
   output logic                   mem_req_o,
   output logic [InstAddrBus-1:0] mem_addr_o,
   output logic [InstAddrBus-1:0] pc_o,
   output logic [InstBus-1:0]     inst_o,
   output logic                   inst_valid_o,
   output logic                   if_stall_o
);

   logic [InstAddrBus-1:0] pc;
   logic [InstBus-1:0]     inst;
   byte_cnt_t              issue_cnt;
   byte_cnt_t              recv_cnt;
   logic                   inst_valid;
   logic                   in_flight;

   logic                   accept;
   logic                   consume;
   logic                   last_byte;
   logic                   hit;
   logic [InstBus-1:0]     hit_data;

`ifdef ICACHE_EN
   logic lookup;
   logic cache_hit;
   logic fill_en;

   // Lookup happens only in the first cycle of a word, before any byte is issued.
   assign lookup  = (issue_cnt == '0) && !inst_valid;
   assign hit     = lookup && cache_hit;
   assign fill_en = in_flight && last_byte && !jump_i;

   icache u_icache (
      .clk          (clk),
      .rst          (rst),
      .lookup_index (pc[ICacheIndexLsb +: ICacheIndexBus]),
      .lookup_tag   (pc[ICacheTagLsb +: ICacheTagBus]),
      .hit          (cache_hit),
      .hit_data     (hit_data),
      .fill_en      (fill_en),
      .fill_index   (pc[ICacheIndexLsb +: ICacheIndexBus]),
      .fill_tag     (pc[ICacheTagLsb +: ICacheTagBus]),
      .fill_data    ({mem_data_i, inst[23:0]})
   );
`else
   assign hit      = 1'b0;
   assign hit_data = ZeroWord;
`endif

   assign last_byte = (recv_cnt == LastByte);
   assign mem_req_o = (rst != RstEnable) && !inst_valid && (issue_cnt != WordBytes) && !hit;
   assign accept    = mem_req_o && mem_grant_i;
   assign consume   = inst_valid && !stall_i;

   // NOTE: every state register uses <= so all updates see the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         pc         <= '0;
         inst       <= ZeroWord;
         issue_cnt  <= '0;
         recv_cnt   <= '0;
         inst_valid <= 1'b0;
         in_flight  <= 1'b0;
      end else if (jump_i) begin
         pc         <= jump_addr_i;
         issue_cnt  <= '0;
         recv_cnt   <= '0;
         inst_valid <= 1'b0;
         in_flight  <= 1'b0;
      end else if (consume) begin
         pc         <= pc + InstAddrBus'(WordBytes);
         issue_cnt  <= '0;
         recv_cnt   <= '0;
         inst_valid <= 1'b0;
         in_flight  <= 1'b0;
      end else if (hit) begin
         inst       <= hit_data;
         inst_valid <= 1'b1;
      end else begin
         // The byte accepted last cycle returns now, whether or not grant is still high.
         in_flight <= accept;
         if (accept) begin
            issue_cnt <= issue_cnt + 3'd1;
         end
         if (in_flight) begin
            inst[{recv_cnt[1:0], 3'b000} +: 8] <= mem_data_i;
            recv_cnt <= recv_cnt + 3'd1;
            if (last_byte) begin
               inst_valid <= 1'b1;
            end
         end
      end
   end

   assign mem_addr_o   = pc + InstAddrBus'(issue_cnt);
   assign pc_o         = pc;
   assign inst_o       = inst;
   assign inst_valid_o = inst_valid;
   assign if_stall_o   = (rst != RstEnable) && !inst_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed cycle-exact scenarios plus a randomized
// phase scored by a word-level fetch model against a behavioural byte memory.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        jump_i = 1'b0;
   logic [31:0] jump_addr_i = '0;
   logic        mem_grant_i = 1'b0;
   logic [7:0]  mem_data_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        if_stall_o;

   int n_checks = 0;
   int n_pass   = 0;

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .jump_i       (jump_i),
      .jump_addr_i  (jump_addr_i),
      .mem_grant_i  (mem_grant_i),
      .mem_data_i   (mem_data_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .pc_o         (pc_o),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o),
      .if_stall_o   (if_stall_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Byte memory contents: a fixed boot word at 0..3, an address hash elsewhere.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h05;
         32'd2:   return 8'h10;
         32'd3:   return 8'h00;
         default: return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   // Memory responder: an accepted request returns its byte in the following cycle.
   logic        acc_q = 1'b0;
   logic [31:0] acc_addr_q = '0;
   always @(posedge clk) begin
      acc_q      <= mem_req_o && mem_grant_i;
      acc_addr_q <= mem_addr_o;
   end
   assign mem_data_i = acc_q ? mem_byte(acc_addr_q) : 8'hEE;

   // Word-level model: which pc the next delivered word must have, and how many of its
   // bytes have been requested so far.
   logic [31:0] exp_pc = '0;
   int          n_iss = 0;
   int          words_seen = 0;
   always @(negedge clk) begin
      if (rst) begin
         exp_pc = '0;
         n_iss  = 0;
      end else begin
         check("mdl_if_stall", if_stall_o, !inst_valid_o);
         if (inst_valid_o) begin
            check("mdl_pc", pc_o, exp_pc);
            check("mdl_inst", inst_o, mem_word(exp_pc));
            check("mdl_req_idle", mem_req_o, 1'b0);
         end
         if (mem_req_o && mem_grant_i) begin
            check("mdl_addr", mem_addr_o, exp_pc + 32'(n_iss));
            n_iss++;
         end
         if (jump_i) begin
            exp_pc = jump_addr_i;
            n_iss  = 0;
         end else if (inst_valid_o && !stall_i) begin
            exp_pc = exp_pc + 32'd4;
            n_iss  = 0;
            words_seen++;
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      jump_i = 1'b0;
      stall_i = 1'b0;
      mem_grant_i = 1'b1;
      repeat (2) next();
      check("rst_pc", pc_o, 32'h0);
      check("rst_inst", inst_o, 32'h0);
      check("rst_valid", inst_valid_o, 1'b0);
      check("rst_req", mem_req_o, 1'b0);
      check("rst_addr", mem_addr_o, 32'h0);
      rst = 1'b0;
      #1;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!inst_valid_o && n < limit) begin
         next();
         n++;
      end
      check("wait_valid", inst_valid_o, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end expected $finish");
      $fatal(1);
   end

   initial begin
      int n;
      int w0;

      // Continuous grant: four byte issues then the assembled word.
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) next();
         if (c <= 4) begin
            check("t23_req", mem_req_o, 1'b1);
            check("t23_addr", mem_addr_o, 32'(c - 1));
         end
         if (c == 5) check("t23_req_done", mem_req_o, 1'b0);
         check("t23_valid", inst_valid_o, c == 6);
      end
      check("t23_pc", pc_o, 32'h0);
      check("t23_inst", inst_o, 32'h00100513);
      next();
      check("t23_pc_next", pc_o, 32'h4);
      check("t23_addr_next", mem_addr_o, 32'h4);
      check("t23_valid_next", inst_valid_o, 1'b0);
      wait_valid(50, n);
      check("t23_lat2", n, 5);
      check("t23_pc2", pc_o, 32'h4);

      // Grant gap after byte 1, then stall while the word is held.
      do_reset();
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) next();
         mem_grant_i = !(c >= 3 && c <= 5);
         stall_i = (c >= 9 && c <= 12);
         if (c <= 9) check("t24_valid", inst_valid_o, c == 9);
         if (c == 3 || c == 6) begin
            check("t24_req", mem_req_o, 1'b1);
            check("t24_addr", mem_addr_o, 32'h2);
         end
         if (c >= 9 && c <= 13) begin
            check("t25_valid", inst_valid_o, 1'b1);
            check("t25_pc", pc_o, 32'h0);
            check("t25_inst", inst_o, 32'h00100513);
            check("t25_req", mem_req_o, 1'b0);
         end
         if (c == 14) begin
            check("t25_pc_adv", pc_o, 32'h4);
            check("t25_valid_clr", inst_valid_o, 1'b0);
            check("t25_req_again", mem_req_o, 1'b1);
         end
      end
      mem_grant_i = 1'b1;
      stall_i = 1'b0;

      // Jump during byte-2 receive, then jump while stalled on a valid word.
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) next();
         jump_i = (c == 4);
         jump_addr_i = 32'h100;
      end
      check("t26_valid", inst_valid_o, 1'b0);
      check("t26_addr", mem_addr_o, 32'h100);
      check("t26_req", mem_req_o, 1'b1);
      wait_valid(50, n);
      check("t26_lat", n, 5);
      check("t26_pc", pc_o, 32'h100);
      check("t26_inst", inst_o, mem_word(32'h100));
      stall_i = 1'b1;
      jump_i = 1'b1;
      jump_addr_i = 32'h200;
      next();
      jump_i = 1'b0;
      stall_i = 1'b0;
      check("t26_stall_jmp_valid", inst_valid_o, 1'b0);
      check("t26_stall_jmp_addr", mem_addr_o, 32'h200);
      wait_valid(50, n);
      check("t26_pc2", pc_o, 32'h200);
      check("t26_inst2", inst_o, mem_word(32'h200));

      // Wrap-around of byte addresses and pc.
      do_reset();
      jump_i = 1'b1;
      jump_addr_i = 32'hFFFF_FFFC;
      next();
      jump_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("t27_addr", mem_addr_o, 32'hFFFF_FFFC + 32'(k));
         next();
      end
      wait_valid(50, n);
      check("t27_pc", pc_o, 32'hFFFF_FFFC);
      check("t27_inst", inst_o, mem_word(32'hFFFF_FFFC));
      next();
      check("t27_pc_wrap", pc_o, 32'h0);
      check("t27_addr_wrap", mem_addr_o, 32'h0);
      wait_valid(50, n);
      check("t27_inst_wrap", inst_o, 32'h00100513);

      // Unaligned target is used as given.
      jump_i = 1'b1;
      jump_addr_i = 32'h103;
      next();
      jump_i = 1'b0;
      check("t13_addr", mem_addr_o, 32'h103);
      wait_valid(50, n);
      check("t13_pc", pc_o, 32'h103);
      check("t13_inst", inst_o, mem_word(32'h103));

`ifdef ICACHE_EN
      // Loop back to 0x40: miss then hit; a jump in the lookup cycle cancels the fill.
      do_reset();
      jump_i = 1'b1;
      jump_addr_i = 32'h40;
      for (int c = 2; c <= 11; c++) begin
         next();
         jump_i = (c == 8 || c == 10);
         jump_addr_i = (c == 8) ? 32'h40 : 32'h44;
         if (c == 2) begin
            check("t28_miss_req", mem_req_o, 1'b1);
            check("t28_miss_addr", mem_addr_o, 32'h40);
         end
         if (c <= 7) check("t28_miss_valid", inst_valid_o, c == 7);
         if (c == 9) begin
            check("t28_hit_req", mem_req_o, 1'b0);
            check("t28_hit_pend", inst_valid_o, 1'b0);
         end
         if (c == 10) begin
            check("t28_hit_valid", inst_valid_o, 1'b1);
            check("t28_hit_pc", pc_o, 32'h40);
            check("t28_hit_inst", inst_o, mem_word(32'h40));
         end
         if (c == 11) check("t28_cancel_fill", mem_req_o, 1'b1);
      end
      jump_i = 1'b0;
      next();
      do_reset();
      jump_i = 1'b1;
      jump_addr_i = 32'h40;
      next();
      jump_i = 1'b0;
      check("t28_rst_miss_req", mem_req_o, 1'b1);
      next();
      check("t28_rst_miss_valid", inst_valid_o, 1'b0);
`endif

      // Randomized traffic scored by the word-level model.
      do_reset();
      w0 = words_seen;
      for (int i = 0; i < 3000; i++) begin
         next();
         mem_grant_i = ($urandom_range(0, 9) < 7);
         stall_i = ($urandom_range(0, 9) < 3);
         jump_i = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 1)
            jump_addr_i = 32'h40 + (32'($urandom_range(0, 7)) << 2);
         else
            jump_addr_i = 32'($urandom_range(0, 16'h3EFF)) << 2;
      end
      jump_i = 1'b0;
      stall_i = 1'b0;
      next();
      check("rand_progress", (words_seen - w0) >= 50, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; port names clk and rst.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_i  in  1  downstream (ID) not ready; hold the presented instruction
jump_i  in  1  redirect request from EX
jump_addr_i  in  32  redirect target
mem_grant_i  in  1  byte memory port granted to fetch this cycle
mem_data_i  in  8  byte returned for the request accepted in the previous cycle
mem_req_o  out  1  fetch wants the memory port
mem_addr_o  out  32  byte address of the current request
pc_o  out  32  address of inst_o
inst_o  out  32  assembled little-endian instruction
inst_valid_o  out  1  pc_o/inst_o valid for the ID stage
if_stall_o  out  1  fetch in progress, no valid instruction

Function
REQ-003 A request SHALL be accepted in a cycle with mem_req_o=1 and mem_grant_i=1; mem_data_i SHALL be captured in the next cycle, independent of mem_grant_i.
REQ-004 Per word, issue count and receive count SHALL each run 0..4; mem_addr_o = pc + issue count; mem_req_o = 1 while issue count < 4 and no word is held.
REQ-005 Byte k SHALL be written to inst_o[8k+7:8k].
REQ-006 After the 4th byte is captured, inst_valid_o SHALL be 1 from the next cycle; if_stall_o = !inst_valid_o outside reset.
REQ-007 Latency with continuous grant SHALL be: first issue in cycle T, inst_valid_o=1 in T+5.
REQ-008 The word SHALL be consumed in the first cycle with inst_valid_o=1 and stall_i=0; at the next edge pc <= pc+4, the counters clear and inst_valid_o <= 0. The next issue happens the cycle after consumption.
REQ-009 While stall_i=1, inst_valid_o, pc_o and inst_o SHALL hold unchanged.
REQ-010 mem_grant_i=0 SHALL only block issue. An in-flight byte SHALL still be captured.
REQ-011 jump_i=1 SHALL override stall_i and any fetch state. At the next edge: pc <= jump_addr_i, counters clear, inst_valid_o <= 0, and any byte in flight is discarded.
REQ-012 pc arithmetic SHALL be 32-bit modulo 2^32. 0xFFFFFFFC+4 wraps to 0x00000000; byte addresses wrap the same way.
REQ-013 jump_addr_i SHALL be used unaligned-as-given; the block does not check alignment.

Reset
REQ-014 On rst=1 at a clock edge, the following SHALL be cleared to 0: pc, counters, inst_o, inst_valid_o, mem_req_o, mem_addr_o, and the in-flight flag. pc_o SHALL be 0.
REQ-015 Reset mid-word SHALL discard all partial bytes.
REQ-016 The first issue SHALL be at address 0, in the cycle after rst deasserts.

Configuration
REQ-017 Macro ICACHE_EN SHALL enable a 32-entry direct-mapped instruction cache with these fields: index pc[6:2], tag pc[17:7], valid bit.
REQ-018 With ICACHE_EN defined, lookup SHALL happen in the first cycle of a word, when issue count = 0.
- Hit: mem_req_o=0, inst_valid_o=1 next cycle (1-cycle latency).
- Miss: byte fetch per REQ-004..007, and the entry is filled when the 4th byte is captured.
- A jump in the lookup cycle cancels the fill.
REQ-019 Cache valid bits SHALL clear on reset only.
REQ-020 Without ICACHE_EN, every word SHALL use the byte fetch and no cache storage SHALL exist.

Structure
REQ-021 The bus widths (InstAddrBus, InstBus), RstEnable, ZeroWord and the cache geometry constants (ICacheIndexBus, ICacheTagBus) SHALL live in the shared defines file.
REQ-022 The cache SHALL be a sub-module named icache, instantiated only under ICACHE_EN.

Verification
REQ-023 Reset, then grant always 1, memory bytes 0x13,0x05,0x10,0x00 at 0..3, stall_i=0 -> mem_addr_o 0,1,2,3 in cycles 1-4; inst_valid_o=1, pc_o=0, inst_o=0x00100513 in cycle 6; pc_o=4 on the next word.
REQ-024 Grant low for 3 cycles after byte 1 issued -> byte 1 still captured; issue resumes at address 2; inst_valid_o delayed exactly 3 cycles versus REQ-023.
REQ-025 stall_i high for 4 cycles while valid -> inst_o/pc_o stable; mem_req_o=0; release -> pc advances to 4 next cycle.
REQ-026 jump_i=1, jump_addr_i=0x100 during byte 2 receive -> inst_valid_o=0 next cycle; next mem_addr_o=0x100; stale byte not in inst_o; jump with stall_i=1 also redirects.
REQ-027 jump to 0xFFFFFFFC -> byte addresses 0xFFFFFFFC..0xFFFFFFFF; next word pc_o=0x00000000.
REQ-028 (ICACHE_EN) Loop jumping back to 0x40 -> first pass 6-cycle fetch; second pass inst_valid_o one cycle after redirect with mem_req_o=0; reset mid-run -> next access at 0x40 misses.
